// File: rtl/i2c_req_arbiter.sv
// Two-requester front end for a single-byte I2C master: round-robin grant,
// ena/busy handshake sequencing, and a per-state watchdog abort.
module i2c_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned TO_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic       req0_rw,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       req0_done,
  output logic [7:0] req0_rdata,
  output logic       req0_err,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic       req1_rw,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       req1_done,
  output logic [7:0] req1_rdata,
  output logic       req1_err,
  output logic       m_ena,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_wr,
  input  logic       m_busy,
  input  logic [7:0] m_data_rd,
  input  logic       m_ack_error,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic [6:0]      addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic            err0_q, err0_d, err1_q, err1_d;
  logic            timeout_q, timeout_d;

  logic            grant_any;
  logic            grant_id;
  logic            load;
  logic [7:0]      res_data;
  logic            res_err;

  // With both valid, the one not served last wins; otherwise the lone requester.
  assign grant_any = req0_valid | req1_valid;
  assign grant_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    timeout_d = timeout_q;
    load      = 1'b0;
    res_data  = 8'h00;
    res_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          state_d = StIssue;
          cnt_d   = '0;
          gnt_d   = grant_id;
          last_d  = grant_id;
          addr_d  = grant_id ? req1_addr  : req0_addr;
          rw_d    = grant_id ? req1_rw    : req0_rw;
          wdata_d = grant_id ? req1_wdata : req0_wdata;
        end
      end
      StIssue: begin
        if (m_busy) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          load      = 1'b1;
          res_err   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StWait: begin
        if (!m_busy) begin
          state_d  = StDone;
          load     = 1'b1;
          res_data = m_data_rd;
          res_err  = m_ack_error;
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          load      = 1'b1;
          res_err   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Results land in the granted requester's registers on entry to DONE and hold there.
  always_comb begin
    rdata0_d = rdata0_q;
    err0_d   = err0_q;
    rdata1_d = rdata1_q;
    err1_d   = err1_q;
    if (load) begin
      if (gnt_q) begin
        rdata1_d = res_data;
        err1_d   = res_err;
      end else begin
        rdata0_d = res_data;
        err0_d   = res_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= 7'h00;
      rw_q      <= 1'b0;
      wdata_q   <= 8'h00;
      rdata0_q  <= 8'h00;
      err0_q    <= 1'b0;
      rdata1_q  <= 8'h00;
      err1_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      err0_q    <= err0_d;
      rdata1_q  <= rdata1_d;
      err1_q    <= err1_d;
      timeout_q <= timeout_d;
    end
  end

  // ready is gated by reset so no grant is signalled while reset is held.
  assign req0_ready = (state_q == StIdle) && !reset && grant_any && !grant_id;
  assign req1_ready = (state_q == StIdle) && !reset && grant_any && grant_id;
  assign req0_done  = (state_q == StDone) && !gnt_q;
  assign req1_done  = (state_q == StDone) && gnt_q;
  assign req0_rdata = rdata0_q;
  assign req0_err   = err0_q;
  assign req1_rdata = rdata1_q;
  assign req1_err   = err1_q;
  assign m_ena      = (state_q == StIssue);
  assign m_addr     = addr_q;
  assign m_rw       = rw_q;
  assign m_data_wr  = wdata_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed scenarios plus random two-requester traffic,
// checked against a transaction-level model and a behavioural I2C master.
module tb_i2c_req_arbiter;

  localparam int TimeoutCycles = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_rw, req0_ready, req0_done, req0_err;
  logic [6:0] req0_addr;
  logic [7:0] req0_wdata, req0_rdata;
  logic       req1_valid, req1_rw, req1_ready, req1_done, req1_err;
  logic [6:0] req1_addr;
  logic [7:0] req1_wdata, req1_rdata;
  logic       m_ena, m_rw, m_busy, m_ack_error, timeout;
  logic [6:0] m_addr;
  logic [7:0] m_data_wr, m_data_rd;

  always #5 clk = ~clk;

  i2c_req_arbiter #(
    .TIMEOUT_CYCLES(TimeoutCycles),
    .TO_W          (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_rw    (req0_rw),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req0_done  (req0_done),
    .req0_rdata (req0_rdata),
    .req0_err   (req0_err),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_rw    (req1_rw),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .req1_done  (req1_done),
    .req1_rdata (req1_rdata),
    .req1_err   (req1_err),
    .m_ena      (m_ena),
    .m_addr     (m_addr),
    .m_rw       (m_rw),
    .m_data_wr  (m_data_wr),
    .m_busy     (m_busy),
    .m_data_rd  (m_data_rd),
    .m_ack_error(m_ack_error),
    .timeout    (timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model state
  int         model_last = 1;
  bit         model_to   = 1'b0;
  int         cur_id;
  logic [6:0] cur_addr;
  logic       cur_rw;
  logic [7:0] cur_wdata;
  bit         cap_pending = 1'b0;
  bit         exp_valid   = 1'b0;
  logic       exp_err;
  logic [7:0] exp_rdata;
  bit         exp_chk_rd;
  int         exp_len;
  int         ena_cnt = 0;
  int         n_done  = 0;
  int         grant_log[$];

  // Master behaviour knobs: mode 0 normal, 1 busy never rises, 2 busy stuck high
  bit         force_on = 1'b0;
  int         f_mode, f_d, f_h;
  logic [7:0] f_data;
  logic       f_ack;

  always @(negedge clk) begin
    if (reset) begin
      ena_cnt     = 0;
      cap_pending = 1'b0;
    end else begin
      if (cap_pending) begin
        check_eq("cap_ena", m_ena, 1);
        check_eq("cap_addr", m_addr, cur_addr);
        check_eq("cap_rw", m_rw, cur_rw);
        check_eq("cap_wdata", m_data_wr, cur_wdata);
        cap_pending = 1'b0;
      end
      if (m_ena) begin
        ena_cnt++;
      end else if (ena_cnt != 0) begin
        check_eq("ena_len", ena_cnt, exp_len);
        ena_cnt = 0;
      end
      if (req0_ready || req1_ready) begin
        int w;
        int id;
        check_eq("ready_excl", req0_ready & req1_ready, 0);
        if (req0_valid && req1_valid) w = (model_last == 0) ? 1 : 0;
        else w = req0_valid ? 0 : 1;
        id = req1_ready ? 1 : 0;
        check_eq("grant_winner", id, w);
        cur_id      = id;
        cur_addr    = id ? req1_addr : req0_addr;
        cur_rw      = id ? req1_rw : req0_rw;
        cur_wdata   = id ? req1_wdata : req0_wdata;
        model_last  = id;
        cap_pending = 1'b1;
        grant_log.push_back(id);
      end
      if (req0_done || req1_done) begin
        int         id;
        logic [7:0] rd;
        logic       er;
        id = req1_done ? 1 : 0;
        rd = id ? req1_rdata : req0_rdata;
        er = id ? req1_err : req0_err;
        check_eq("done_excl", req0_done & req1_done, 0);
        check_eq("done_id", id, cur_id);
        check_eq("done_expected", exp_valid, 1);
        check_eq("done_err", er, exp_err);
        if (exp_chk_rd) check_eq("done_rdata", rd, exp_rdata);
        check_eq("done_timeout", timeout, model_to);
        exp_valid = 1'b0;
        n_done++;
      end
    end
  end

  // Behavioural I2C master
  initial begin
    m_busy      = 1'b0;
    m_data_rd   = 8'h00;
    m_ack_error = 1'b0;
    forever begin
      int         md, d, h;
      logic [7:0] dat;
      logic       ack;
      @(negedge clk);
      if (m_ena && !reset) begin
        if (force_on) begin
          md = f_mode; d = f_d; h = f_h; dat = f_data; ack = f_ack;
        end else begin
          md  = ($urandom_range(9) == 0) ? 1 : 0;
          d   = $urandom_range(6);
          h   = $urandom_range(30, 1);
          dat = 8'($urandom);
          ack = ($urandom_range(4) == 0);
        end
        exp_valid = 1'b1;
        if (md == 1) begin
          exp_len = TimeoutCycles; exp_err = 1'b1; exp_chk_rd = 1'b0; model_to = 1'b1;
          for (int i = 0; i < TimeoutCycles + 10; i++) begin
            @(negedge clk);
            if (!m_ena) break;
          end
        end else begin
          exp_len = d + 1;
          if (md == 2) begin
            exp_err = 1'b1; exp_rdata = 8'h00; exp_chk_rd = 1'b1; model_to = 1'b1;
            h = TimeoutCycles + 10;
          end else begin
            exp_err = ack; exp_rdata = dat; exp_chk_rd = cur_rw;
          end
          repeat (d) @(posedge clk);
          #1 m_busy = 1'b1;
          repeat (h) @(posedge clk);
          #1;
          m_data_rd   = dat;
          m_ack_error = ack;
          m_busy      = 1'b0;
        end
      end
    end
  end

  task automatic send(input int id, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    bit got;
    @(posedge clk);
    #1;
    if (id == 0) begin
      req0_addr = a; req0_rw = rw; req0_wdata = wd; req0_valid = 1'b1;
    end else begin
      req1_addr = a; req1_rw = rw; req1_wdata = wd; req1_valid = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
    end
    check_eq(id == 0 ? "ready0_seen" : "ready1_seen", got, 1);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && n_done < target; i++) @(negedge clk);
    check_eq("done_count", n_done, target);
  endtask

  task automatic wait_bus_idle();
    for (int i = 0; i < 500 && m_busy; i++) @(negedge clk);
    check_eq("bus_idle", m_busy, 0);
  endtask

  task automatic rand_traffic(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(8)) @(posedge clk);
      send(id, 7'($urandom), 1'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b0; req0_addr = 7'h00; req0_rw = 1'b0; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_addr = 7'h00; req1_rw = 1'b0; req1_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #3;
    check_eq("rst_ena", m_ena, 0);
    check_eq("rst_mbus", {m_addr, m_rw, m_data_wr}, 0);
    check_eq("rst_hs", {req0_ready, req0_done, req1_ready, req1_done}, 0);
    check_eq("rst_res", {req0_rdata, req0_err, req1_rdata, req1_err, timeout}, 0);
    reset = 1'b0;

    // Single read from requester 0
    force_on = 1'b1; f_mode = 0; f_d = 3; f_h = 40; f_data = 8'hA5; f_ack = 1'b0;
    send(0, 7'h20, 1'b1, 8'h00);
    wait_done(1);
    check_eq("t1_rdata", req0_rdata, 8'hA5);
    check_eq("t1_err", req0_err, 0);
    check_eq("t1_req1_quiet", {req1_rdata, req1_err}, 0);

    // NACK on requester 1 write
    f_d = 2; f_h = 10; f_data = 8'h00; f_ack = 1'b1;
    send(1, 7'h3C, 1'b0, 8'h5E);
    wait_done(2);
    check_eq("t3_wdata", m_data_wr, 8'h5E);
    check_eq("t3_err", req1_err, 1);
    check_eq("t3_timeout", timeout, 0);

    // Contention: both held, expect strict alternation starting with 0
    f_d = 1; f_h = 5; f_ack = 1'b0;
    grant_log.delete();
    fork
      begin send(0, 7'h11, 1'b1, 8'h01); send(0, 7'h12, 1'b0, 8'h02); end
      begin send(1, 7'h21, 1'b1, 8'h03); send(1, 7'h22, 1'b0, 8'h04); end
    join
    wait_done(6);
    check_eq("t2_ngrants", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size(); i++) check_eq("t2_order", grant_log[i], i % 2);

    // Busy never rises: ISSUE watchdog, then timeout stays sticky
    f_mode = 1;
    send(0, 7'h30, 1'b1, 8'h00);
    wait_done(7);
    check_eq("t4_err", req0_err, 1);
    check_eq("t4_timeout", timeout, 1);
    f_mode = 0; f_d = 2; f_h = 6; f_data = 8'h3C;
    send(1, 7'h31, 1'b1, 8'h00);
    wait_done(8);
    check_eq("t4_sticky", timeout, 1);

    // Busy stuck high: WAIT watchdog, then requester 0 is served normally
    f_mode = 2; f_d = 2; f_data = 8'hFF; f_ack = 1'b0;
    send(1, 7'h44, 1'b1, 8'h00);
    wait_done(9);
    check_eq("t5_err", req1_err, 1);
    check_eq("t5_rdata", req1_rdata, 0);
    wait_bus_idle();
    f_mode = 0; f_d = 1; f_h = 4; f_data = 8'h77;
    grant_log.delete();
    send(0, 7'h45, 1'b1, 8'h00);
    wait_done(10);
    check_eq("t5_next_gnt", grant_log[0], 0);
    check_eq("t5_next_rdata", req0_rdata, 8'h77);

    // Random traffic
    force_on = 1'b0;
    fork
      rand_traffic(0, 12);
      rand_traffic(1, 12);
    join
    wait_done(34);

    // Reset asserted asynchronously while in WAIT
    force_on = 1'b1; f_mode = 0; f_d = 1; f_h = 20; f_data = 8'h12;
    fork
      send(0, 7'h50, 1'b1, 8'h00);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (m_busy && !m_ena) begin
            seen = 1'b1;
            break;
          end
        end
        check_eq("t6_in_wait", seen, 1);
      end
    join
    @(posedge clk);
    #3;
    reset      = 1'b1;
    exp_valid  = 1'b0;
    model_last = 1;
    model_to   = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_eq("t6_ena", m_ena, 0);
    check_eq("t6_ready", {req0_ready, req1_ready}, 0);
    check_eq("t6_done", {req0_done, req1_done}, 0);
    check_eq("t6_timeout", timeout, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #15 reset = 1'b0;
    wait_bus_idle();
    grant_log.delete();
    f_d = 0; f_h = 3;
    fork
      send(0, 7'h51, 1'b0, 8'h9A);
      send(1, 7'h52, 1'b0, 8'h9B);
    join
    wait_done(n_done + 1);
    wait_done(36);
    check_eq("t6_first_gnt", grant_log[0], 0);
    check_eq("final_timeout", timeout, model_to);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
